fb_host_link: RTL and testbench
===============================

Name: fb_host_link

Overview:
Host-side (FPGA/bench) endpoint of the SPM fallback serial link. It drives `fb_en`, `fb_d_in` and `fb_d_in_vld` into the chip, and receives `fb_d_out`, `fb_d_out_vld` and `fb_d_clsc` from the chip.
- TX path: serializes 36-bit packets.
- RX path: deserializes chip-returned bits into 36-bit words and buffers them in a small FIFO.
- Host logic sees the same deq/empty/rdata style used by the mesh FIFOs.

Parameters:
- PKT_W, 36, frame payload width in bits (matches `packet_t` / SPM `FIFO_WIDTH`).
- RX_DEPTH, 2, RX FIFO entries; power of two, ≥2.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-low.
- link_en  in  1  host enable; registered and driven out as `fb_en_o`.
- tx_data  in  PKT_W  packet to send.
- tx_vld  in  1  `tx_data` valid.
- tx_rdy  out  1  TX accepts a packet this cycle.
- rx_deq  in  1  pop RX FIFO head.
- rx_empty  out  1  RX FIFO empty.
- rx_rdata  out  PKT_W  RX FIFO head (valid when `!rx_empty`).
- rx_overflow  out  1  sticky: a received word was dropped.
- fb_en_o  out  1  to chip `fb_en`.
- fb_d_in_o  out  1  to chip `fb_d_in`.
- fb_d_in_vld_o  out  1  to chip `fb_d_in_vld`.
- fb_d_out_i  in  1  from chip `fb_d_out`.
- fb_d_out_vld_i  in  1  from chip `fb_d_out_vld`.
- fb_d_clsc_i  in  1  from chip `fb_d_clsc`; 1 = chip cannot take bits (stall).

Behaviour:
- Reset (`rst`==0 at posedge): all state cleared.
  - `fb_en_o`=0, `fb_d_in_o`=0, `fb_d_in_vld_o`=0.
  - `tx_rdy`=0, `rx_empty`=1, `rx_rdata`=0, `rx_overflow`=0.
  - TX FSM = IDLE, bit counters = 0.
  - A reset mid-frame discards the partial TX and RX frames.
- Input registration:
  - `link_en_q` <= `link_en`; `fb_en_o` = `link_en_q`.
  - `clsc_q` <= `fb_d_clsc_i`.
  - `fb_d_out_i` and `fb_d_out_vld_i` are sampled directly.
- TX FSM states: IDLE, SHIFT, STALL.
  - IDLE: `tx_rdy` = `link_en_q`. On `tx_vld && tx_rdy`, latch `tx_data` into the shift register, set bit index to 0, go to SHIFT.
  - SHIFT:
    - If `clsc_q`==0: drive `fb_d_in_vld_o`=1 and `fb_d_in_o` = shreg[idx], LSB first, then increment idx.
    - After bit PKT_W-1 is launched, go to IDLE.
    - If `clsc_q`==1: `fb_d_in_vld_o`=0, idx is held, go to STALL.
  - STALL: `vld`=0. Return to SHIFT on the first cycle with `clsc_q`==0, resuming at the held idx.
  - All TX outputs are registered.
  - Latency: a handshake in cycle N puts bit 0 on the pins in cycle N+1.
  - A frame uses exactly PKT_W vld-high cycles. `tx_rdy` is high again in the cycle after the last bit. With no stalls, one frame takes PKT_W+1 cycles.
  - `fb_d_in_o` holds its last value whenever `vld`=0.
- `link_en_q` falling in SHIFT or STALL: abort.
  - Go to IDLE, `vld`=0, partial frame dropped.
  - `tx_rdy` stays 0 until `link_en_q` returns to 1.
- RX:
  - In each cycle with `fb_d_out_vld_i`=1 and `link_en_q`=1, shift `fb_d_out_i` into rx_shreg at index rx_idx (LSB first) and increment rx_idx.
  - When rx_idx reaches PKT_W, push the word and set rx_idx to 0.
  - A word whose last bit is sampled in cycle M is visible (`rx_empty`=0) in cycle M+1.
  - `link_en_q`==0 clears rx_idx; the partial word is dropped.
- RX FIFO:
  - Push into a full FIFO: word dropped, `rx_overflow` set; it is cleared only by reset.
  - Push and `rx_deq` in the same cycle while full: both take effect, no overflow.
  - `rx_deq` while empty: ignored.
  - Pointers wrap modulo RX_DEPTH, with a separate count (0..RX_DEPTH) for full/empty.
- TX and RX are fully independent; simultaneous activity is allowed.

Optional Feature:
- Macro: `FB_HOST_PARITY_EN`.
- When defined:
  - TX appends one even-parity bit (XOR of all PKT_W bits) as frame bit PKT_W, so a frame is PKT_W+1 vld cycles.
  - RX collects PKT_W+1 bits and checks parity.
  - On a mismatch, the word is dropped (not pushed) and a new output `rx_par_err` (sticky, reset 0) is set.
- When undefined: frames are PKT_W bits, and the `rx_par_err` port does not exist.

Decomposition:
- Package `fb_link_pkg` holds:
  - `localparam FB_PKT_W` = 36.
  - `typedef enum logic [1:0] {FB_TX_IDLE, FB_TX_SHIFT, FB_TX_STALL} fb_tx_state_t`.
  - `function fb_parity(logic [FB_PKT_W-1:0])`.
- Sub-module `fb_rx_fifo`: a parameterized sync FIFO (push, deq, full, empty, rdata) with same-cycle push/deq support.

Test Plan:
- Reset, then `link_en`=1 → `tx_rdy`=1 on the 2nd cycle. Send 36'h9_A5A5_A5A5 → `fb_d_in_vld_o` high for 36 consecutive cycles, bits LSB-first 1,0,1,0,0,1,…; `tx_rdy`=0 during the frame and 1 in the cycle after.
- Raise `fb_d_clsc_i` for 3 cycles mid-frame (after bit 10) → `vld` low for 3 cycles, resumes at bit 11, total 36 vld-high cycles, data intact.
- Drive 36'h0_0000_0001 and 36'hF_FFFF_FFFE serially on `fb_d_out_i` → `rx_rdata` = those values in order, each visible 1 cycle after its last bit; `rx_deq` pops them.
- With RX_DEPTH=2 and no deq, receive 3 words → the first two are retained, the third is dropped, `rx_overflow`=1. A push with simultaneous deq while full → no overflow.
- Drop `link_en` after 20 TX bits and 20 RX bits → `vld`=0, TX in IDLE. Re-enable and send fresh frames → clean 36-bit frames with no stale bits. Assert `rst`=0 mid-frame → all outputs at their reset values.
- With `FB_HOST_PARITY_EN`: send 36'h0_0000_0003 → 37th bit = 0. Inject an RX frame with a flipped parity bit → not pushed, `rx_par_err`=1.

Source files
------------

// File: rtl/fb_link_pkg.sv
// fb_host_link shared types: packet width, TX FSM states, parity helper.
// Parity framing is enabled with the FB_HOST_PARITY_EN macro.
package fb_link_pkg;

  localparam int FB_PKT_W = 36;

  typedef enum logic [1:0] {
    FB_TX_IDLE,
    FB_TX_SHIFT,
    FB_TX_STALL
  } fb_tx_state_t;

  function automatic logic fb_parity(
    input logic [FB_PKT_W-1:0] d
  );
    return ^d;
  endfunction

endpackage

// File: rtl/fb_host_link_if.sv
// Host-side packet bus of fb_host_link: TX valid/ready, RX FIFO pop.
// master = host logic, slave = link endpoint.
interface fb_host_link_if #(
  parameter int PKT_W = fb_link_pkg::FB_PKT_W
);

  logic             link_en;
  logic [PKT_W-1:0] tx_data;
  logic             tx_vld;
  logic             tx_rdy;
  logic             rx_deq;
  logic             rx_empty;
  logic [PKT_W-1:0] rx_rdata;
  logic             rx_overflow;

  modport master (
    output link_en,
    output tx_data,
    output tx_vld,
    input  tx_rdy,
    output rx_deq,
    input  rx_empty,
    input  rx_rdata,
    input  rx_overflow
  );

  modport slave (
    input  link_en,
    input  tx_data,
    input  tx_vld,
    output tx_rdy,
    input  rx_deq,
    output rx_empty,
    output rx_rdata,
    output rx_overflow
  );

endinterface

// File: rtl/fb_rx_fifo.sv
// Small sync FIFO for received words; push and pop may coincide,
// including while full.
module fb_rx_fifo #(
  parameter int W     = 36,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         deq,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = deq && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/fb_host_link.sv
// Host endpoint of the SPM fallback serial link (TX serializer, RX FIFO).
// Define FB_HOST_PARITY_EN to append/check an even-parity frame bit.
module fb_host_link
  import fb_link_pkg::*;
#(
  parameter int PKT_W    = FB_PKT_W,
  parameter int RX_DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  fb_host_link_if.slave host,
  output logic fb_en_o,
  output logic fb_d_in_o,
  output logic fb_d_in_vld_o,
  input  logic fb_d_out_i,
  input  logic fb_d_out_vld_i,
  input  logic fb_d_clsc_i
`ifdef FB_HOST_PARITY_EN
  ,
  output logic rx_par_err
`endif
);

`ifdef FB_HOST_PARITY_EN
  localparam int FW = PKT_W + 1;
`else
  localparam int FW = PKT_W;
`endif
  localparam int IW = $clog2(FW + 1);
  localparam logic [IW-1:0] TX_END  = IW'(FW);
  localparam logic [IW-1:0] RX_LAST = IW'(FW - 1);

  logic link_en_q;
  logic clsc_q;

  fb_tx_state_t  state;
  fb_tx_state_t  state_nxt;
  logic [FW-1:0] tx_frame;
  logic [FW-1:0] tx_sh;
  logic [FW-1:0] tx_sh_nxt;
  logic [IW-1:0] tx_idx;
  logic [IW-1:0] tx_idx_nxt;
  logic          d_nxt;
  logic          vld_nxt;
  logic          tx_fire;

`ifdef FB_HOST_PARITY_EN
  assign tx_frame = {fb_parity(host.tx_data), host.tx_data};
`else
  assign tx_frame = host.tx_data;
`endif

  assign host.tx_rdy = (state == FB_TX_IDLE) && link_en_q;
  assign tx_fire     = host.tx_vld && host.tx_rdy;
  assign fb_en_o     = link_en_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      link_en_q     <= 1'b0;
      clsc_q        <= 1'b0;
      state         <= FB_TX_IDLE;
      tx_sh         <= '0;
      tx_idx        <= '0;
      fb_d_in_o     <= 1'b0;
      fb_d_in_vld_o <= 1'b0;
    end else begin
      link_en_q     <= host.link_en;
      clsc_q        <= fb_d_clsc_i;
      state         <= state_nxt;
      tx_sh         <= tx_sh_nxt;
      tx_idx        <= tx_idx_nxt;
      fb_d_in_o     <= d_nxt;
      fb_d_in_vld_o <= vld_nxt;
    end
  end

  // tx_idx counts launched bits; TX_END means the last bit is on the pins.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FB_TX_IDLE: begin
        if (tx_fire) state_nxt = clsc_q ? FB_TX_STALL : FB_TX_SHIFT;
      end
      FB_TX_SHIFT,
      FB_TX_STALL: begin
        if (!link_en_q || tx_idx == TX_END) state_nxt = FB_TX_IDLE;
        else if (clsc_q)                   state_nxt = FB_TX_STALL;
        else                               state_nxt = FB_TX_SHIFT;
      end
      default: state_nxt = FB_TX_IDLE;
    endcase
  end

  always_comb begin
    tx_sh_nxt  = tx_sh;
    tx_idx_nxt = tx_idx;
    d_nxt      = fb_d_in_o;
    vld_nxt    = 1'b0;
    unique case (state)
      FB_TX_IDLE: begin
        if (tx_fire) begin
          tx_sh_nxt  = tx_frame;
          tx_idx_nxt = '0;
          if (!clsc_q) begin
            d_nxt      = tx_frame[0];
            vld_nxt    = 1'b1;
            tx_idx_nxt = IW'(1);
          end
        end
      end
      FB_TX_SHIFT,
      FB_TX_STALL: begin
        if (link_en_q && tx_idx != TX_END && !clsc_q) begin
          d_nxt      = tx_sh[tx_idx];
          vld_nxt    = 1'b1;
          tx_idx_nxt = tx_idx + IW'(1);
        end
      end
      default: ;
    endcase
  end

  logic [FW-1:0] rx_sh;
  logic [FW-1:0] rx_word;
  logic [IW-1:0] rx_idx;
  logic          rx_done;
  logic          rx_push;
  logic          rx_full;
  logic          rx_ovf;

  always_comb begin
    rx_word         = rx_sh;
    rx_word[FW-1]   = fb_d_out_i;
  end

  assign rx_done = fb_d_out_vld_i && link_en_q && (rx_idx == RX_LAST);

`ifdef FB_HOST_PARITY_EN
  logic rx_ok;
  assign rx_ok   = ~^rx_word;
  assign rx_push = rx_done && rx_ok;
`else
  assign rx_push = rx_done;
`endif

  assign host.rx_overflow = rx_ovf;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_sh  <= '0;
      rx_idx <= '0;
      rx_ovf <= 1'b0;
    end else begin
      if (!link_en_q) begin
        rx_idx <= '0;
      end else if (fb_d_out_vld_i) begin
        rx_sh[rx_idx] <= fb_d_out_i;
        rx_idx        <= rx_done ? '0 : rx_idx + IW'(1);
      end
      if (rx_push && rx_full && !host.rx_deq) rx_ovf <= 1'b1;
    end
  end

`ifdef FB_HOST_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst)                  rx_par_err <= 1'b0;
    else if (rx_done && !rx_ok) rx_par_err <= 1'b1;
  end
`endif

  fb_rx_fifo #(
    .W     (PKT_W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_push),
    .wdata (rx_word[PKT_W-1:0]),
    .deq   (host.rx_deq),
    .full  (rx_full),
    .empty (host.rx_empty),
    .rdata (host.rx_rdata)
  );

endmodule

// File: tb/tb_fb_host_link.sv
// Directed self-checking bench for fb_host_link.
// Parity scenarios build only when FB_HOST_PARITY_EN is defined.
module tb_fb_host_link;

  localparam int PKT_W = 36;
`ifdef FB_HOST_PARITY_EN
  localparam int FW = PKT_W + 1;
`else
  localparam int FW = PKT_W;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic fb_en_o;
  logic fb_d_in_o;
  logic fb_d_in_vld_o;
  logic fb_d_out_i;
  logic fb_d_out_vld_i;
  logic fb_d_clsc_i;
`ifdef FB_HOST_PARITY_EN
  logic rx_par_err;
`endif

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  fb_host_link_if #(.PKT_W(PKT_W)) host ();

  fb_host_link #(
    .PKT_W    (PKT_W),
    .RX_DEPTH (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .host           (host),
    .fb_en_o        (fb_en_o),
    .fb_d_in_o      (fb_d_in_o),
    .fb_d_in_vld_o  (fb_d_in_vld_o),
    .fb_d_out_i     (fb_d_out_i),
    .fb_d_out_vld_i (fb_d_out_vld_i),
    .fb_d_clsc_i    (fb_d_clsc_i)
`ifdef FB_HOST_PARITY_EN
    ,
    .rx_par_err     (rx_par_err)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] frame_of(input logic [PKT_W-1:0] w);
`ifdef FB_HOST_PARITY_EN
    return {^w, w};
`else
    return w;
`endif
  endfunction

  task automatic pop;
    host.rx_deq = 1'b1;
    tick;
    host.rx_deq = 1'b0;
  endtask

  task automatic tx_frame(
    input  logic [PKT_W-1:0] w,
    input  int               stall_at,
    output logic [FW-1:0]    got,
    output int               nvld,
    output int               nlow,
    output int               rdy_bad,
    output bit               tmo
  );
    int sc;
    bit started;
    got = '0; nvld = 0; nlow = 0; rdy_bad = 0;
    tmo = 1'b1; sc = 0; started = 1'b0;
    host.tx_data = w;
    host.tx_vld  = 1'b1;
    tick;
    host.tx_vld  = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (fb_d_in_vld_o) begin
        if (nvld < FW) got[nvld] = fb_d_in_o;
        nvld++;
        started = 1'b1;
      end else if (started) begin
        nlow++;
      end
      if (host.tx_rdy) rdy_bad++;
      if (fb_d_in_vld_o && nvld == stall_at) begin
        fb_d_clsc_i = 1'b1;
        sc = 3;
      end else if (sc > 0) begin
        sc--;
        if (sc == 0) fb_d_clsc_i = 1'b0;
      end
      if (nvld >= FW) begin
        tmo = 1'b0;
        break;
      end
      tick;
    end
  endtask

  task automatic rx_send(
    input  logic [FW-1:0] f,
    input  bit            deq_last,
    output logic          empty_pre
  );
    empty_pre = 1'b0;
    for (int i = 0; i < FW; i++) begin
      fb_d_out_i     = f[i];
      fb_d_out_vld_i = 1'b1;
      if (i == FW - 1) begin
        host.rx_deq = deq_last;
        empty_pre   = host.rx_empty;
      end
      tick;
    end
    fb_d_out_vld_i = 1'b0;
    host.rx_deq    = 1'b0;
  endtask

  task automatic test_reset;
    logic [5:0] v;
    rst = 1'b0;
    host.link_en = 1'b0;
    tick; tick; tick;
    v = {fb_en_o, fb_d_in_o, fb_d_in_vld_o,
         host.tx_rdy, host.rx_empty, host.rx_overflow};
    nchk++;
    if (v !== 6'b000010) begin
      nerr++;
      $display("FAIL reset_flags: got %b want 000010", v);
    end
    nchk++;
    if (host.rx_rdata !== '0) begin
      nerr++;
      $display("FAIL reset_rdata: got %h want 0", host.rx_rdata);
    end
`ifdef FB_HOST_PARITY_EN
    nchk++;
    if (rx_par_err !== 1'b0) begin
      nerr++;
      $display("FAIL reset_par_err: got %b want 0", rx_par_err);
    end
`endif
  endtask

  task automatic test_enable;
    rst = 1'b1;
    host.link_en = 1'b1;
    tick;
    nchk++;
    if ({fb_en_o, host.tx_rdy} !== 2'b11) begin
      nerr++;
      $display("FAIL enable: got en/rdy %b want 11", {fb_en_o, host.tx_rdy});
    end
  endtask

  task automatic check_frame(
    input string          name,
    input logic [PKT_W-1:0] w,
    input int             stall_at,
    input int             want_low
  );
    logic [FW-1:0] got;
    int nvld, nlow, rdy_bad;
    bit tmo;
    tx_frame(w, stall_at, got, nvld, nlow, rdy_bad, tmo);
    nchk++;
    if (tmo || nvld != FW) begin
      nerr++;
      $display("FAIL %s_len: got %0d vld bits want %0d", name, nvld, FW);
    end
    nchk++;
    if (got !== frame_of(w)) begin
      nerr++;
      $display("FAIL %s_data: got %h want %h", name, got, frame_of(w));
    end
    nchk++;
    if (nlow != want_low || rdy_bad != 0) begin
      nerr++;
      $display("FAIL %s_gap: got low=%0d rdy=%0d want low=%0d rdy=0",
               name, nlow, rdy_bad, want_low);
    end
    tick;
    nchk++;
    if ({host.tx_rdy, fb_d_in_vld_o} !== 2'b10) begin
      nerr++;
      $display("FAIL %s_end: got rdy/vld %b want 10", name,
               {host.tx_rdy, fb_d_in_vld_o});
    end
  endtask

  task automatic test_tx_basic;
    check_frame("tx_basic", 36'h9_A5A5_A5A5, -1, 0);
  endtask

  task automatic test_tx_stall;
    check_frame("tx_stall", 36'h5_3C96_E10F, 10, 3);
  endtask

  task automatic test_rx;
    logic e;
    rx_send(frame_of(36'h0_0000_0001), 1'b0, e);
    nchk++;
    if ({e, host.rx_empty} !== 2'b10 || host.rx_rdata !== 36'h1) begin
      nerr++;
      $display("FAIL rx_first: got pre=%b empty=%b data=%h want 1 0 1",
               e, host.rx_empty, host.rx_rdata);
    end
    rx_send(frame_of(36'hF_FFFF_FFFE), 1'b0, e);
    nchk++;
    if (host.rx_rdata !== 36'h1) begin
      nerr++;
      $display("FAIL rx_head: got %h want 1", host.rx_rdata);
    end
    pop;
    nchk++;
    if (host.rx_rdata !== 36'hF_FFFF_FFFE || host.rx_empty !== 1'b0) begin
      nerr++;
      $display("FAIL rx_second: got %h want ffffffffe", host.rx_rdata);
    end
    pop;
    pop;
    nchk++;
    if ({host.rx_empty, host.rx_overflow} !== 2'b10 ||
        host.rx_rdata !== '0) begin
      nerr++;
      $display("FAIL rx_drain: got empty=%b ovf=%b data=%h want 1 0 0",
               host.rx_empty, host.rx_overflow, host.rx_rdata);
    end
  endtask

  task automatic test_full_deq;
    logic e;
    rx_send(frame_of(36'h1_1111_1111), 1'b0, e);
    rx_send(frame_of(36'h2_2222_2222), 1'b0, e);
    rx_send(frame_of(36'h3_3333_3333), 1'b1, e);
    nchk++;
    if (host.rx_overflow !== 1'b0 || host.rx_rdata !== 36'h2_2222_2222) begin
      nerr++;
      $display("FAIL full_deq: got ovf=%b data=%h want 0 222222222",
               host.rx_overflow, host.rx_rdata);
    end
    pop;
    nchk++;
    if (host.rx_rdata !== 36'h3_3333_3333) begin
      nerr++;
      $display("FAIL full_deq_tail: got %h want 333333333", host.rx_rdata);
    end
    pop;
  endtask

  task automatic test_overflow;
    logic e;
    rx_send(frame_of(36'hD_0000_000D), 1'b0, e);
    rx_send(frame_of(36'hE_0000_000E), 1'b0, e);
    rx_send(frame_of(36'hF_0000_000F), 1'b0, e);
    nchk++;
    if (host.rx_overflow !== 1'b1 || host.rx_rdata !== 36'hD_0000_000D) begin
      nerr++;
      $display("FAIL ovf_set: got ovf=%b data=%h want 1 d0000000d",
               host.rx_overflow, host.rx_rdata);
    end
    pop;
    nchk++;
    if (host.rx_rdata !== 36'hE_0000_000E) begin
      nerr++;
      $display("FAIL ovf_second: got %h want e0000000e", host.rx_rdata);
    end
    pop;
    nchk++;
    if (host.rx_empty !== 1'b1) begin
      nerr++;
      $display("FAIL ovf_dropped: got empty=%b want 1", host.rx_empty);
    end
  endtask

  task automatic test_link_drop;
    logic [PKT_W-1:0] rw;
    logic e;
    int tcnt, rcnt;
    rw = 36'hA_BCDE_F012;
    tcnt = 0; rcnt = 0;
    host.tx_data = 36'hC_3C3C_3C3C;
    host.tx_vld  = 1'b1;
    tick;
    host.tx_vld  = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (fb_d_in_vld_o) tcnt++;
      if (rcnt < 20) begin
        fb_d_out_i     = rw[rcnt];
        fb_d_out_vld_i = 1'b1;
        rcnt++;
      end else begin
        fb_d_out_vld_i = 1'b0;
      end
      if (tcnt >= 20 && rcnt >= 20) break;
      tick;
    end
    nchk++;
    if (tcnt < 20) begin
      nerr++;
      $display("FAIL drop_progress: got %0d tx bits want 20", tcnt);
    end
    tick;
    host.link_en   = 1'b0;
    fb_d_out_vld_i = 1'b0;
    tick;
    tick;
    nchk++;
    if ({fb_en_o, fb_d_in_vld_o, host.tx_rdy} !== 3'b000) begin
      nerr++;
      $display("FAIL drop_abort: got en/vld/rdy %b want 000",
               {fb_en_o, fb_d_in_vld_o, host.tx_rdy});
    end
    tick;
    nchk++;
    if ({fb_d_in_vld_o, host.rx_empty} !== 2'b01) begin
      nerr++;
      $display("FAIL drop_idle: got vld/empty %b want 01",
               {fb_d_in_vld_o, host.rx_empty});
    end
    host.link_en = 1'b1;
    tick;
    check_frame("drop_tx_fresh", 36'h1_2345_6789, -1, 0);
    rx_send(frame_of(36'h8_0000_0001), 1'b0, e);
    nchk++;
    if (e !== 1'b1 || host.rx_rdata !== 36'h8_0000_0001) begin
      nerr++;
      $display("FAIL drop_rx_fresh: got pre=%b data=%h want 1 800000001",
               e, host.rx_rdata);
    end
    pop;
  endtask

  task automatic test_mid_reset;
    logic [5:0] v;
    logic e;
    rx_send(frame_of(36'h0_DEAD_BEEF), 1'b0, e);
    host.tx_data = 36'hF_FFFF_FFFF;
    host.tx_vld  = 1'b1;
    tick;
    host.tx_vld  = 1'b0;
    for (int c = 0; c < 5; c++) begin
      fb_d_out_i     = 1'b1;
      fb_d_out_vld_i = 1'b1;
      tick;
    end
    fb_d_out_vld_i = 1'b0;
    nchk++;
    if ({fb_d_in_vld_o, fb_d_in_o, host.rx_empty} !== 3'b110) begin
      nerr++;
      $display("FAIL midrst_pre: got vld/d/empty %b want 110",
               {fb_d_in_vld_o, fb_d_in_o, host.rx_empty});
    end
    rst = 1'b0;
    tick;
    v = {fb_en_o, fb_d_in_o, fb_d_in_vld_o,
         host.tx_rdy, host.rx_empty, host.rx_overflow};
    nchk++;
    if (v !== 6'b000010 || host.rx_rdata !== '0) begin
      nerr++;
      $display("FAIL midrst_state: got %b data=%h want 000010 0",
               v, host.rx_rdata);
    end
    rst = 1'b1;
    tick;
    rx_send(frame_of(36'h7_0F0F_0F0F), 1'b0, e);
    nchk++;
    if (e !== 1'b1 || host.rx_rdata !== 36'h7_0F0F_0F0F) begin
      nerr++;
      $display("FAIL midrst_rx: got pre=%b data=%h want 1 70f0f0f0f",
               e, host.rx_rdata);
    end
    pop;
    check_frame("midrst_tx", 36'h0_0000_0FFF, -1, 0);
  endtask

`ifdef FB_HOST_PARITY_EN
  task automatic test_parity;
    logic [FW-1:0] f;
    logic e;
    check_frame("par_tx", 36'h0_0000_0003, -1, 0);
    f = frame_of(36'h0_0000_0005);
    f[FW-1] = ~f[FW-1];
    rx_send(f, 1'b0, e);
    tick;
    nchk++;
    if ({host.rx_empty, rx_par_err} !== 2'b11) begin
      nerr++;
      $display("FAIL par_rx: got empty/err %b want 11",
               {host.rx_empty, rx_par_err});
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    host.link_en   = 1'b0;
    host.tx_data   = '0;
    host.tx_vld    = 1'b0;
    host.rx_deq    = 1'b0;
    fb_d_out_i     = 1'b0;
    fb_d_out_vld_i = 1'b0;
    fb_d_clsc_i    = 1'b0;
    test_reset;
    test_enable;
    test_tx_basic;
    test_tx_stall;
    test_rx;
    test_full_deq;
    test_overflow;
    test_link_drop;
    test_mid_reset;
`ifdef FB_HOST_PARITY_EN
    test_parity;
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
